// File: rtl/count_seq.sv
// Prescaled 0..LAST_COUNT sequencer with one-shot/loop runs, pause and abort.
// Drives the count consumed by the address range decoder plus aligned step/wrap/done pulses.
module count_seq #(
    parameter int PRESCALE   = 4,
    parameter int LAST_COUNT = 174,
    parameter int PRE_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       mode,
    output logic [7:0] count,
    output logic       step,
    output logic       wrap,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [7:0]       CNT_LAST = 8'(LAST_COUNT);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       count_q, count_d;
    logic             mode_q, mode_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Next-state and output decode; RUN and PAUSED share the advance path so
    // the cycle that releases pause also advances the prescaler.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        count_d = count_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                count_d = 8'd0;
                pre_d   = '0;
                if (start && !stop) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    mode_d  = mode;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN, ST_PAUSED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    count_d = 8'd0;
                    pre_d   = '0;
                    busy_d  = 1'b0;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (pre_q < PRE_LAST) begin
                    state_d = ST_RUN;
                    pre_d   = pre_q + PRE_ONE;
                end else begin
                    state_d = ST_RUN;
                    pre_d   = '0;
                    step_d  = 1'b1;
                    if (count_q < CNT_LAST) begin
                        count_d = count_q + 8'd1;
                    end else if (mode_q) begin
                        count_d = 8'd0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = 8'd0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 8'd0;
                pre_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            count_q <= 8'd0;
            mode_q  <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign count = count_q;
    assign step  = step_q;
    assign wrap  = wrap_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule
